// File: rtl/mux2x1_stream_arb.sv
// ---------------------------------------------------------------------------
// mux2x1_stream_arb
//   Two-input, one-output stream arbiter feeding a 2:1 mux datapath.
//   Picks between source a and source b with round-robin fairness on ties.
//   The grant is held for the length of a packet. Each winning beat is
//   registered, and the granted source is exported as y_sel. y_sel drives
//   the downstream mux select. One beat per cycle is sustained.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   a_valid  in   source a beat valid
//   a_data   in   source a data  [WIDTH]
//   a_last   in   source a final beat of packet
//   a_ready  out  source a beat accepted this cycle
//   b_valid  in   source b beat valid
//   b_data   in   source b data  [WIDTH]
//   b_last   in   source b final beat of packet
//   b_ready  out  source b beat accepted this cycle
//   y_valid  out  output beat valid (registered)
//   y_data   out  output data (registered) [WIDTH]
//   y_last   out  output final-beat flag (registered)
//   y_sel    out  source of the beat in y_data: 0=a, 1=b (registered)
//   y_ready  in   downstream accepts y
// ---------------------------------------------------------------------------
module mux2x1_stream_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  output logic             y_sel,
  input  logic             y_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;        // last source served: 0=a, 1=b
  logic             w_ptr_nxt;

  logic             r_y_valid;
  logic [WIDTH-1:0] r_y_data;
  logic             r_y_last;
  logic             r_y_sel;

  logic             w_accept;
  logic             w_gnt_vld;    // some source holds the grant this cycle
  logic             w_gnt_b;      // granted source: 0=a, 1=b
  logic             w_xfer;
  logic             w_xfer_last;

  // The output register can take a beat when it is empty or draining now.
  assign w_accept = !r_y_valid | y_ready;

  // Grant selection. In IDLE, ptr==1 means b was served last, so a wins the
  // tie. While locked, the grant stays with the packet owner even if that
  // owner has dropped valid, and the other source stalls.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_b   = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt_vld = a_valid | b_valid;
        w_gnt_b   = (a_valid & b_valid) ? !r_ptr : b_valid;
      end
      LOCK_A: begin
        w_gnt_vld = 1'b1;
        w_gnt_b   = 1'b0;
      end
      LOCK_B: begin
        w_gnt_vld = 1'b1;
        w_gnt_b   = 1'b1;
      end
      default: begin
        w_gnt_vld = 1'b0;
        w_gnt_b   = 1'b0;
      end
    endcase
  end

  assign a_ready     = w_accept & w_gnt_vld & !w_gnt_b;
  assign b_ready     = w_accept & w_gnt_vld &  w_gnt_b;
  assign w_xfer      = (a_valid & a_ready) | (b_valid & b_ready);
  assign w_xfer_last = w_gnt_b ? b_last : a_last;

  // Packet lock tracking. The state and the pointer change only on a transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    if (w_xfer) begin
      case (r_state)
        IDLE: begin
          if (w_xfer_last) begin
            w_ptr_nxt = w_gnt_b;
          end else begin
            w_state_nxt = w_gnt_b ? LOCK_B : LOCK_A;
          end
        end
        LOCK_A, LOCK_B: begin
          if (w_xfer_last) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = w_gnt_b;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Output register stage: load on transfer, clear valid once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
      r_y_last  <= 1'b0;
      r_y_sel   <= 1'b0;
    end else if (w_xfer) begin
      r_y_valid <= 1'b1;
      r_y_data  <= w_gnt_b ? b_data : a_data;
      r_y_last  <= w_xfer_last;
      r_y_sel   <= w_gnt_b;
    end else if (y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  assign y_valid = r_y_valid;
  assign y_data  = r_y_data;
  assign y_last  = r_y_last;
  assign y_sel   = r_y_sel;

endmodule

// File: tb/tb_mux2x1_stream_arb.sv
// ---------------------------------------------------------------------------
// tb_mux2x1_stream_arb
//   Directed bench for mux2x1_stream_arb. The stimulus pushes each expected
//   output beat {sel,last,data} into a queue. A monitor pops and compares
//   every beat the DUT hands downstream. Ready and hold behaviour are checked
//   inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_mux2x1_stream_arb;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             a_valid, a_last, a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid, b_last, b_ready;
  logic [WIDTH-1:0] b_data;
  logic             y_valid, y_last, y_sel, y_ready;
  logic [WIDTH-1:0] y_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH+1:0] exp_q[$];

  mux2x1_stream_arb #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_last  (y_last),
    .y_sel   (y_sel),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic sel, input logic last, input logic [WIDTH-1:0] data);
    exp_q.push_back({sel, last, data});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every beat handed downstream must match the queue head.
  always @(negedge clk) begin
    if (rst_n && y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_unexpected: got sel=%0d last=%0d data=%0h, expected no beat",
                 y_sel, y_last, y_data);
      end else begin
        chk("beat", {22'd0, y_sel, y_last, y_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rr_pat;
    int ia;
    int ib;

    rst_n = 1'b0; y_ready = 1'b0;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    #2;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data",  y_data,  0);
    chk("rst_y_last",  y_last,  0);
    chk("rst_y_sel",   y_sel,   0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    #5 rst_n = 1'b1;

    // Single-beat packet from a.
    step;
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1; y_ready = 1'b1;
    #1;
    chk("t1_a_ready", a_ready, 1);
    chk("t1_b_ready", b_ready, 0);
    push(1'b0, 1'b1, 8'h11);
    step;
    a_valid = 1'b0;
    #1;
    chk("t1_y_valid", y_valid, 1);
    chk("t1_y_data",  y_data,  8'h11);
    chk("t1_y_sel",   y_sel,   0);
    chk("t1_y_last",  y_last,  1);

    // Both valid, single-beat packets. a was served last, so b leads.
    rr_pat = 5'b10101;
    ia = 0; ib = 0;
    push(1'b1, 1'b1, 8'hB0);
    push(1'b0, 1'b1, 8'hA0);
    push(1'b1, 1'b1, 8'hB1);
    push(1'b0, 1'b1, 8'hA1);
    push(1'b1, 1'b1, 8'hB2);
    for (int c = 0; c < 5; c++) begin
      step;
      a_valid = 1'b1; a_last = 1'b1; a_data = 8'hA0 + 8'(ia);
      b_valid = 1'b1; b_last = 1'b1; b_data = 8'hB0 + 8'(ib);
      #1;
      chk("rr_b_ready", b_ready, rr_pat[c]);
      chk("rr_a_ready", a_ready, !rr_pat[c]);
      if (a_ready) ia++;
      if (b_ready) ib++;
    end

    // Packet lock: a sends 3 beats while b stays valid. b gets the next turn.
    push(1'b0, 1'b0, 8'hC0);
    push(1'b0, 1'b0, 8'hC1);
    push(1'b0, 1'b1, 8'hC2);
    push(1'b1, 1'b1, 8'hD0);
    for (int c = 0; c < 4; c++) begin
      step;
      a_valid = 1'b1; a_data = 8'hC0 + 8'(c); a_last = (c == 2);
      b_valid = 1'b1; b_data = 8'hD0; b_last = 1'b1;
      #1;
      chk("lock_a_ready", a_ready, (c < 3));
      chk("lock_b_ready", b_ready, (c == 3));
    end

    // Backpressure.
    step;
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
    step;
    a_valid = 1'b1; a_data = 8'h5A; a_last = 1'b1;
    #1;
    chk("bp_a_ready_first", a_ready, 1);
    push(1'b0, 1'b1, 8'h5A);
    for (int c = 0; c < 4; c++) begin
      step;
      y_ready = 1'b0; a_data = 8'h5B;
      #1;
      chk("bp_a_ready_stall", a_ready, 0);
      chk("bp_y_valid", y_valid, 1);
      chk("bp_y_data",  y_data,  8'h5A);
      chk("bp_y_sel",   y_sel,   0);
    end
    step;
    y_ready = 1'b1;
    #1;
    chk("bp_a_ready_release", a_ready, 1);
    push(1'b0, 1'b1, 8'h5B);
    step;
    a_valid = 1'b0;

    // Lock with gap on b. a was served last, so b wins the tie.
    step;
    a_valid = 1'b1; a_data = 8'hF0; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'hE0; b_last = 1'b0;
    #1;
    chk("gap_b_ready", b_ready, 1);
    chk("gap_a_ready", a_ready, 0);
    push(1'b1, 1'b0, 8'hE0);
    for (int c = 0; c < 2; c++) begin
      step;
      b_valid = 1'b0;
      #1;
      chk("gap_a_stall", a_ready, 0);
    end
    step;
    b_valid = 1'b1; b_data = 8'hE1;
    #1;
    chk("gap_b_resume", b_ready, 1);
    push(1'b1, 1'b0, 8'hE1);

    // Async reset mid-packet while in LOCK_B. Beat E2 is discarded.
    step;
    b_data = 8'hE2;
    #1;
    chk("ar_b_ready", b_ready, 1);
    step;
    y_ready = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("ar_y_data_held", y_data, 8'hE2);
    chk("ar_y_sel_held",  y_sel,  1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_y_valid", y_valid, 0);
    chk("ar_y_sel",   y_sel,   0);
    chk("ar_y_data",  y_data,  0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step;
    a_valid = 1'b1; a_data = 8'h66; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'h77; b_last = 1'b1;
    y_ready = 1'b1;
    #1;
    chk("ar_a_first", a_ready, 1);
    chk("ar_b_wait",  b_ready, 0);
    push(1'b0, 1'b1, 8'h66);
    step;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) step;

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
